// File: rtl/ikaopll_busq.sv
// Host write queue for the IKAOPLL bus port: buffers {A0,D} writes and replays them with YM2413 strobe/wait timing.
// Optional sticky overflow flag enabled by defining IKAOPLL_BUSQ_OVF_FLAG_EN.
module ikaopll_busq #(
    parameter int DEPTH      = 16,
    parameter int STROBE_LEN = 4,
    parameter int ADDR_WAIT  = 12,
    parameter int DATA_WAIT  = 84
) (
    input  logic                       i_EMUCLK,
    input  logic                       i_RST,
    input  logic                       i_phiM_PCEN_n,
    input  logic                       i_VALID,
    output logic                       o_READY,
    input  logic                       i_A0,
    input  logic [7:0]                 i_D,
    output logic [$clog2(DEPTH):0]     o_LEVEL,
    output logic                       o_EMPTY,
    output logic                       o_BUSY,
    output logic                       o_OVF,
    output logic                       o_CS_n,
    output logic                       o_WR_n,
    output logic                       o_A0,
    output logic [7:0]                 o_D
);
    localparam int PW   = $clog2(DEPTH);
    localparam int LW   = PW + 1;
    localparam int MAXW = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
    localparam int WW   = $clog2(MAXW + 1);
    localparam int SW   = $clog2(STROBE_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_WAIT   = 3'd4
    } state_t;

    state_t          state, state_nx;
    logic [SW-1:0]   strb_cnt, strb_cnt_nx;
    logic [WW-1:0]   wait_cnt, wait_cnt_nx;
    logic            cs_n_nx, wr_n_nx, a0_nx;
    logic [7:0]      d_nx;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level_nx;
    logic [8:0]      mem [DEPTH];
    logic            tick, push, pop;

    assign tick = ~i_phiM_PCEN_n;
    // o_READY is registered from occupancy, so a push at full is refused even if a pop coincides
    assign push = i_VALID & o_READY;
    assign pop  = tick & (state == ST_IDLE) & (o_LEVEL != LW'(0));
    assign level_nx = o_LEVEL + LW'(push) - LW'(pop);

    // FIFO storage; no reset needed since pointers and level define validity
    always_ff @(posedge i_EMUCLK) begin
        if (push) begin
            mem[wr_ptr] <= {i_A0, i_D};
        end
    end

    // Replay sequencer next-state and bus drive
    always_comb begin
        state_nx    = state;
        strb_cnt_nx = strb_cnt;
        wait_cnt_nx = wait_cnt;
        cs_n_nx     = o_CS_n;
        wr_n_nx     = o_WR_n;
        a0_nx       = o_A0;
        d_nx        = o_D;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (o_LEVEL != LW'(0)) begin
                        state_nx      = ST_SETUP;
                        cs_n_nx       = 1'b0;
                        wr_n_nx       = 1'b1;
                        {a0_nx, d_nx} = mem[rd_ptr];
                    end else begin
                        cs_n_nx = 1'b1;
                        wr_n_nx = 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_nx    = ST_STROBE;
                    wr_n_nx     = 1'b0;
                    strb_cnt_nx = SW'(STROBE_LEN);
                end
                ST_STROBE: begin
                    if (strb_cnt <= SW'(1)) begin
                        state_nx    = ST_HOLD;
                        wr_n_nx     = 1'b1;
                        strb_cnt_nx = SW'(0);
                    end else begin
                        strb_cnt_nx = strb_cnt - SW'(1);
                    end
                end
                ST_HOLD: begin
                    state_nx    = ST_WAIT;
                    cs_n_nx     = 1'b1;
                    wait_cnt_nx = o_A0 ? WW'(DATA_WAIT) : WW'(ADDR_WAIT);
                end
                ST_WAIT: begin
                    if (wait_cnt <= WW'(1)) begin
                        state_nx    = ST_IDLE;
                        wait_cnt_nx = WW'(0);
                    end else begin
                        wait_cnt_nx = wait_cnt - WW'(1);
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    cs_n_nx  = 1'b1;
                    wr_n_nx  = 1'b1;
                end
            endcase
        end else begin
            state_nx = state;
        end
    end

    // State, pointers and all registered outputs
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            state    <= ST_IDLE;
            strb_cnt <= SW'(0);
            wait_cnt <= WW'(0);
            wr_ptr   <= PW'(0);
            rd_ptr   <= PW'(0);
            o_LEVEL  <= LW'(0);
            o_EMPTY  <= 1'b1;
            o_READY  <= 1'b1;
            o_BUSY   <= 1'b0;
            o_CS_n   <= 1'b1;
            o_WR_n   <= 1'b1;
            o_A0     <= 1'b0;
            o_D      <= 8'h00;
        end else begin
            state    <= state_nx;
            strb_cnt <= strb_cnt_nx;
            wait_cnt <= wait_cnt_nx;
            wr_ptr   <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr   <= pop  ? rd_ptr + PW'(1) : rd_ptr;
            o_LEVEL  <= level_nx;
            o_EMPTY  <= (level_nx == LW'(0));
            o_READY  <= (level_nx != LW'(DEPTH));
            o_BUSY   <= (state_nx != ST_IDLE) || (level_nx != LW'(0));
            o_CS_n   <= cs_n_nx;
            o_WR_n   <= wr_n_nx;
            o_A0     <= a0_nx;
            o_D      <= d_nx;
        end
    end

`ifdef IKAOPLL_BUSQ_OVF_FLAG_EN
    logic ovf;

    // Sticky: any request seen while the queue reports not-ready
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf | (i_VALID & ~o_READY);
        end
    end

    assign o_OVF = ovf;
`else
    assign o_OVF = 1'b0;
`endif

endmodule
